register_scan_controller: RTL and testbench

REGISTER_SCAN_CONTROLLER -- requirements
Module: register_scan_controller

---
 rtl/register_scan_controller_pkg.sv | 32 +++
 rtl/register_scan_controller_match.sv | 26 ++
 rtl/register_scan_controller.sv | 120 ++++++++++++
 tb/tb_register_scan_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/register_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_scan_controller_pkg
// Purpose  : Shared sizes, key/flag positions and FSM encodings for the
//            register scan controller, register file and print module.
// Revision : 1.0 - initial release
// ============================================================================
package register_scan_controller_pkg;

    localparam int c_num_regs = 32;
    localparam int c_data_w   = 32;
    localparam int c_idx_w    = 5;
    localparam int c_key_w    = 10;
    localparam int c_key_lsb  = 0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_scan = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_st_idle,
        SCAN = c_st_scan,
        DONE = c_st_done
    } scan_state_t;

    // The active flag always sits in the top bit of a register entry.
    function automatic int flag_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_scan_controller_match.sv
`default_nettype none
// ============================================================================
// Module   : register_match_unit
// Purpose  : Flags a register entry that is active and carries the scan key.
// Revision : 1.0 - initial release
// ============================================================================
module register_match_unit
    import register_scan_controller_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic [DATA_W-1:0]  data_in,
    input  logic [c_key_w-1:0] key,
    output logic               match
);

    localparam int c_flag = flag_bit(DATA_W);

    // Payload bits between the key field and the flag do not take part.
    logic w_unused_bits;
    assign w_unused_bits = ^data_in;

    assign match = data_in[c_flag] && (data_in[c_key_lsb +: c_key_w] == key);

endmodule
`default_nettype wire

// File: rtl/register_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : register_scan_controller
// Purpose  : Walks register indices 1..NUM_REGS-1 looking for the first
//            active entry whose key field equals the requested key.
// Revision : 1.0 - initial release
// ============================================================================
module register_scan_controller
    import register_scan_controller_pkg::*;
#(
    parameter int NUM_REGS = c_num_regs,
    parameter int DATA_W   = c_data_w
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [c_key_w-1:0] key_in,
    input  logic               write_req,
    input  logic [DATA_W-1:0]  data_in,
    output logic               selector,
    output logic [c_idx_w-1:0] check_R,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [c_idx_w-1:0] hit_R
);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REGS - 1);
    localparam logic [c_idx_w-1:0] c_first_idx = c_idx_w'(1);

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_key_w-1:0] r_key;
    logic               r_exhausted;
    logic               r_pipe_vld;
    logic [c_idx_w-1:0] r_pipe_idx;
    logic               r_hit;
    logic [c_idx_w-1:0] r_hit_r;

    logic w_issue;
    logic w_eval;
    logic w_match;
    logic w_found;
    logic w_last;
    logic w_accept;

    register_match_unit #(
        .DATA_W (DATA_W)
    ) u_match (
        .data_in (data_in),
        .key     (r_key),
        .match   (w_match)
    );

    // The decoder owns the register file port whenever it asks for it.
    assign w_accept = (r_state == IDLE) && start;
    assign w_issue  = (r_state == SCAN) && !write_req && !r_exhausted;
    assign w_eval   = (r_state == SCAN) && r_pipe_vld;
    assign w_found  = w_eval && w_match;
    assign w_last   = w_eval && (r_pipe_idx == c_last_idx);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SCAN;
            SCAN:    if (w_found || w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_key       <= '0;
            r_exhausted <= 1'b0;
            r_pipe_vld  <= 1'b0;
            r_pipe_idx  <= '0;
            r_hit       <= 1'b0;
            r_hit_r     <= '0;
        end else begin
            r_state <= w_state_nxt;
            // An index still in flight when the scan finishes is dropped.
            r_pipe_vld <= w_issue && (w_state_nxt == SCAN);

            if (w_accept) begin
                r_key       <= key_in;
                r_idx       <= c_first_idx;
                r_exhausted <= 1'b0;
                r_hit       <= 1'b0;
                r_hit_r     <= '0;
            end

            if (w_issue) begin
                r_pipe_idx <= r_idx;
                if (r_idx == c_last_idx) begin
                    r_exhausted <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end

            if (w_found) begin
                r_hit   <= 1'b1;
                r_hit_r <= r_pipe_idx;
            end
        end
    end

    assign selector = write_req;
    assign check_R  = w_issue ? r_idx : '0;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign hit      = r_hit;
    assign hit_R    = r_hit_r;

endmodule
`default_nettype wire

// File: tb/tb_register_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_scan_controller
// Purpose  : Directed scans against a small register file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_scan_controller;
    import register_scan_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  key_in;
    logic        write_req;
    logic [31:0] data_in;
    logic        selector;
    logic [4:0]  check_R;
    logic        busy;
    logic        done;
    logic        hit;
    logic [4:0]  hit_R;

    logic [31:0] regs [0:31];
    logic [4:0]  write_R;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the latest scan
    logic [4:0] issued [$];
    int         done_win;
    int         done_cnt;
    int         sel_err;
    int         busy_err;
    logic       res_hit;
    logic [4:0] res_hit_R;
    logic       late_hit;
    logic       busy_after_rst;
    logic [4:0] chk_after_rst;

    always #5 clk = ~clk;

    register_scan_controller #(
        .NUM_REGS (32),
        .DATA_W   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .write_req (write_req),
        .data_in   (data_in),
        .selector  (selector),
        .check_R   (check_R),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .hit_R     (hit_R)
    );

    // Register file read port: data follows the muxed index by one cycle.
    always @(posedge clk) data_in <= regs[selector ? write_R : check_R];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int seq_ok();
        for (int i = 0; i < issued.size(); i++)
            if (issued[i] != 5'(i + 1)) return 0;
        return 1;
    endfunction

    function automatic int max_issued();
        int m = 0;
        for (int i = 0; i < issued.size(); i++)
            if (int'(issued[i]) > m) m = int'(issued[i]);
        return m;
    endfunction

    task automatic clear_regs(input logic [31:0] v);
        for (int i = 0; i < 32; i++) regs[i] = v;
    endtask

    // Window w is the cycle following the w-th rising edge after start is taken.
    task automatic run_scan(input logic [9:0] key, input int stall_at, input int stall_len,
                            input int rst_at, input int start_at, input logic [9:0] alt_key);
        issued.delete();
        done_win = -1; done_cnt = 0; sel_err = 0; busy_err = 0;
        res_hit = 1'b0; res_hit_R = '0; busy_after_rst = 1'bx; chk_after_rst = 'x;
        key_in = key;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = key ^ 10'h3ff;
        for (int w = 0; w < 60; w++) begin
            write_req = (w >= stall_at) && (w < stall_at + stall_len);
            reset     = (w == rst_at);
            start     = (w == start_at);
            if (w == start_at) key_in = alt_key;
            @(negedge clk);
            if (selector !== write_req) sel_err++;
            if (check_R != 5'd0) issued.push_back(check_R);
            if (w == rst_at + 1) begin
                busy_after_rst = busy;
                chk_after_rst  = check_R;
            end
            if (done) begin
                done_cnt++;
                if (done_win < 0) begin
                    done_win  = w;
                    res_hit   = hit;
                    res_hit_R = hit_R;
                end
            end else if (done_win < 0 && rst_at < 0 && busy !== 1'b1) begin
                busy_err++;
            end
            late_hit = hit;
            @(posedge clk); #1;
        end
        write_req = 1'b0; reset = 1'b0; start = 1'b0;
    endtask

    initial begin
        write_R   = 5'd7;
        reset     = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        write_req = 1'b1;
        clear_regs(32'h0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_check_R", 32'(check_R), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_hit_R", 32'(hit_R), 32'd0);
        check("rst_selector", 32'(selector), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; write_req = 1'b0;
        @(posedge clk); #1;

        // Miss: every entry carries the key but only reg 0 is active.
        clear_regs(32'h0000_0155);
        regs[0] = 32'h8000_0155;
        run_scan(10'h155, -1, 0, -1, -1, 10'h0);
        check("miss_done_win", done_win, 32);
        check("miss_hit", 32'(res_hit), 32'd0);
        check("miss_hit_R", 32'(res_hit_R), 32'd0);
        check("miss_issue_cnt", issued.size(), 31);
        check("miss_issue_seq", seq_ok(), 1);
        check("miss_busy", busy_err, 0);
        check("miss_done_cnt", done_cnt, 1);

        // Hit at reg 5.
        clear_regs(32'h0);
        regs[5] = 32'h8000_0155;
        run_scan(10'h155, -1, 0, -1, -1, 10'h0);
        check("hit5_done_win", done_win, 6);
        check("hit5_hit", 32'(res_hit), 32'd1);
        check("hit5_hit_R", 32'(res_hit_R), 32'd5);
        check("hit5_max_issue", max_issued(), 6);
        check("hit5_hold", 32'(late_hit), 32'd1);
        check("hit5_selector", sel_err, 0);

        // Active-flag gating.
        clear_regs(32'h0);
        regs[3] = 32'h0000_0155;
        regs[9] = 32'h8000_0155;
        run_scan(10'h155, -1, 0, -1, -1, 10'h0);
        check("flag_hit_R", 32'(res_hit_R), 32'd9);
        check("flag_done_win", done_win, 10);

        // Last entry matches; upper payload bits do not matter.
        clear_regs(32'h0);
        regs[31] = 32'hffff_fd55;
        run_scan(10'h155, -1, 0, -1, -1, 10'h0);
        check("last_hit", 32'(res_hit), 32'd1);
        check("last_hit_R", 32'(res_hit_R), 32'd31);
        check("last_done_win", done_win, 32);

        // Decoder stall of 4 cycles on a miss scan.
        clear_regs(32'h0);
        run_scan(10'h155, 10, 4, -1, -1, 10'h0);
        check("stall_done_win", done_win, 36);
        check("stall_selector", sel_err, 0);
        check("stall_issue_cnt", issued.size(), 31);
        check("stall_issue_seq", seq_ok(), 1);

        // Reset mid-scan, then a fresh scan.
        clear_regs(32'h0);
        regs[20] = 32'h8000_0155;
        run_scan(10'h155, -1, 0, 10, -1, 10'h0);
        check("rstmid_busy", 32'(busy_after_rst), 32'd0);
        check("rstmid_check_R", 32'(chk_after_rst), 32'd0);
        check("rstmid_done_cnt", done_cnt, 0);
        run_scan(10'h155, -1, 0, -1, -1, 10'h0);
        check("rescan_first", issued.size() > 0 ? 32'(issued[0]) : 32'hdead, 32'd1);
        check("rescan_hit_R", 32'(res_hit_R), 32'd20);
        check("rescan_done_win", done_win, 21);

        // Start while scanning is ignored.
        clear_regs(32'h0);
        regs[3] = 32'h8000_02aa;
        regs[5] = 32'h8000_0155;
        run_scan(10'h155, -1, 0, -1, 1, 10'h2aa);
        check("busystart_hit_R", 32'(res_hit_R), 32'd5);
        check("busystart_done_cnt", done_cnt, 1);
        check("busystart_done_win", done_win, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
